alu32_divider: RTL and testbench
================================

# alu32_divider

Multi-cycle 32-bit signed/unsigned integer divider that drives the existing 32-bit ripple ALU as its trial-subtract datapath. It uses one restoring step per clock. It sits beside the ALU in the execute stage, takes operands through a start/busy handshake, and returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse.

## Interface
- `WIDTH`, 32, operand width. Only 32 is supported, because the ALU slice chain is fixed at 32.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request. It is accepted only on an edge where `busy` is low.
- `is_signed` input 1: 1 selects two's-complement division; 0 selects unsigned. Sampled on accept.
- `a` input 32: dividend. Sampled on accept.
- `b` input 32: divisor. Sampled on accept.
- `busy` output 1: high while a division is in flight.
- `done` output 1: one-cycle pulse when results become valid.
- `quotient` output 32: held until the next completion.
- `remainder` output 32: held until the next completion.
- `div_by_zero` output 1: qualifies the current results. Held with them.

## Operation
- States:
  - IDLE → RUN on accept when b≠0.
  - IDLE → FIX on accept when b=0.
  - RUN → FIX after 32 steps.
  - FIX → IDLE, pulsing `done`.
- On accept:
  - Latch the sign flags: `neg_q = is_signed & (a[31]^b[31])` and `neg_r = is_signed & a[31]`.
  - Latch magnitudes: |a| and |b|, with plain values when unsigned.
  - Load partial remainder R=0 and a 5-bit step counter=31.
- RUN step, MSB-first:
  - Form T = {R, dividend_msb} (33 bits).
  - The ALU instance computes T[31:0] − |b| with opcode SUB (ainv=0, binv=1, cin=1, op=ADD).
  - Take the subtraction when `T[32] | alu_cout` is set. In that case R ← ALU result and the quotient bit is 1.
  - Otherwise R ← T[31:0] and the quotient bit is 0.
  - The quotient bit shifts into the dividend register.
  - The counter decrements. The last step occurs at counter=0.
- FIX:
  - quotient = neg_q ? −Q : Q.
  - remainder = neg_r ? −R : R.
  - `div_by_zero` = 0.
- Divide by zero, in FIX:
  - quotient = 0xFFFFFFFF.
  - remainder = original a.
  - `div_by_zero` = 1.
  - No signed correction is applied.
- Signed overflow, 0x80000000 / −1: falls out of the magnitude path with no special case. Result is quotient 0x80000000, remainder 0, div_by_zero 0.
- `start` while `busy` is ignored. Inputs are not re-sampled, and in-flight state is unaffected.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0.
- Accept edge is E0. `busy` rises after E0.
- Normal path:
  - RUN occupies E1..E32. FIX is evaluated at E33.
  - `quotient`, `remainder` and `div_by_zero` update at E33.
  - `done` is high for exactly the cycle after E33; `busy` falls after E33.
  - Latency is 33 cycles.
- Zero-divisor path: results update and `done` pulses after E1, so latency is 1 cycle.
- Back-to-back: `start` may be asserted in the same cycle `done` is high, since `busy` is already low. The next accept then happens on that edge.
- Reset asserted mid-operation:
  - Aborts immediately and returns to IDLE.
  - No `done` is produced.
  - Outputs return to their reset values.
- The ALU path is combinational within one cycle. The 32-slice ripple sets the clock period.

## Structure
- Shared package `alu32_pkg`:
  - Opcode constants: OP_AND 4'b0000, OP_OR 4'b0001, OP_ADD 4'b0010, OP_SUB 4'b0110, OP_SLT 4'b0111, OP_NOR 4'b1100.
  - Divider state enum: IDLE, RUN, FIX.
- One sub-module: a single instance of the existing 32-bit ALU, tied to OP_SUB. Its `result` and `cout` are used; `overflow` is left unconnected.
- Everything else lives in the divider:
  - Control FSM.
  - Counter.
  - Dividend/quotient shift register.
  - Partial-remainder register.
  - Sign-fix negators.

## Test plan
- Unsigned 100/7 (a=0x64, b=0x7, is_signed=0) → quotient 14, remainder 2, div_by_zero 0. `done` comes exactly 33 cycles after accept, and `busy` is high for all 33 cycles.
- Signed −7/2 (a=0xFFFFFFF9, b=2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. The same operands unsigned give quotient 0x7FFFFFFC, remainder 1.
- Divide by zero (a=0x1234, b=0, either signedness) → `done` after 1 cycle, quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero 1.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF) → quotient 0x80000000, remainder 0, div_by_zero 0. Also run unsigned 0xFFFFFFFF/1 → quotient 0xFFFFFFFF, remainder 0.
- `start` pulsed with new operands at cycle 10 of a busy division → ignored. The original result is delivered, and only one `done` pulse occurs.
- `rst` asserted at cycle 20 of a division → `busy`, `done` and outputs go to 0 immediately, with no `done` pulse. A fresh 100/7 issued after release completes normally.

Source files
------------

// File: rtl/alu32_pkg.sv
// Shared definitions for the 32-bit ripple ALU and the multi-cycle divider
// built on top of it.
package alu32_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    // Two's-complement magnitude when signed, pass-through when unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_s);
        return (is_s && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/alu32_divider_alu.sv
// 32-slice ripple ALU: opcode is {ainv, binv, op[1:0]}, carry-in follows binv.
module alu32_divider_alu
    import alu32_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  op_i,
    output logic [31:0] result_o,
    output logic        cout_o,
    output logic        overflow_o
);

    logic        ainv;
    logic        binv;
    logic [31:0] aa;
    logic [31:0] bb;
    logic [31:0] sum;
    logic [32:0] cy;
    logic        slt;

    assign ainv = op_i[3];
    assign binv = op_i[2];
    assign aa   = ainv ? ~a_i : a_i;
    assign bb   = binv ? ~b_i : b_i;

    always_comb begin
        cy    = '0;
        sum   = '0;
        cy[0] = binv;
        for (int i = 0; i < 32; i++) begin
            sum[i]  = aa[i] ^ bb[i] ^ cy[i];
            cy[i+1] = (aa[i] & bb[i]) | (aa[i] & cy[i]) | (bb[i] & cy[i]);
        end
    end

    assign cout_o     = cy[32];
    assign overflow_o = cy[32] ^ cy[31];
    assign slt        = sum[31] ^ overflow_o;

    always_comb begin
        result_o = '0;
        case (op_i[1:0])
            2'b00:   result_o = aa & bb;
            2'b01:   result_o = aa | bb;
            2'b10:   result_o = sum;
            default: result_o = {31'b0, slt};
        endcase
    end

endmodule

// File: rtl/alu32_divider.sv
// Restoring 32-bit signed/unsigned divider, one quotient bit per clock,
// using the ripple ALU as its trial subtractor.
module alu32_divider
    import alu32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e       state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf_unused;
    logic             take;

    // Low 32 bits of the shifted trial value {R, dividend_msb}; bit 32 is rem_q[31].
    assign alu_a = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    assign take  = rem_q[WIDTH-1] | alu_cout;

    alu32_divider_alu u_alu (
        .a_i        (alu_a),
        .b_i        (dvs_q),
        .op_i       (OP_SUB),
        .result_o   (alu_res),
        .cout_o     (alu_cout),
        .overflow_o (alu_ovf_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    neg_q_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_r_d = is_signed & a[WIDTH-1];
                    rem_d   = '0;
                    cnt_d   = 5'd31;
                    dvs_d   = mag32(b, is_signed);
                    // On a zero divisor the dividend register keeps raw a for the remainder.
                    if (b == '0) begin
                        zero_d  = 1'b1;
                        dvd_d   = a;
                        state_d = FIX;
                    end else begin
                        zero_d  = 1'b0;
                        dvd_d   = mag32(a, is_signed);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = take ? alu_res : alu_a;
                dvd_d = {dvd_q[WIDTH-2:0], take};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (zero_q) begin
                    quot_d = '1;
                    remo_d = dvd_q;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = neg_q_q ? (~dvd_q + 32'd1) : dvd_q;
                    remo_d = neg_r_q ? (~rem_q + 32'd1) : rem_q;
                    dbz_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu32_divider.sv
// Scoreboard bench for alu32_divider: driver queues expected results, a
// monitor compares them on every done pulse.
module tb_alu32_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;

    alu32_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.z});
            end
        end
    end

    task automatic run_div(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                           input logic [31:0] eq, input logic [31:0] er, input logic ez,
                           input int lat, input int inject_at, input int rst_at);
        int   n;
        int   busy_n;
        int   dc0;
        exp_t e;
        @(negedge clk);
        a = av; b = bv; is_signed = sv; start = 1'b1;
        e.q = eq; e.r = er; e.z = ez;
        exp_q.push_back(e);
        dc0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        busy_n = 0;
        while (!done && n < 100) begin
            if (busy) busy_n++;
            if (n == inject_at) begin
                a = 32'd55; b = 32'd3; is_signed = 1'b1; start = 1'b1;
            end else if (n == inject_at + 1) begin
                start = 1'b0;
            end
            if (n == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst busy", {31'b0, busy}, 32'd0);
                chk("rst done", {31'b0, done}, 32'd0);
                chk("rst quotient", quotient, 32'd0);
                chk("rst remainder", remainder, 32'd0);
                chk("rst div_by_zero", {31'b0, div_by_zero}, 32'd0);
                exp_q.delete(exp_q.size() - 1);
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("rst no done", {31'b0, done}, 32'd0);
                end
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, lat);
        chk("busy cycles", busy_n, lat);
        if (inject_at >= 0) begin
            repeat (3) @(posedge clk);
            #1;
            chk("single done", done_cnt - dc0, 32'd1);
        end
    endtask

    initial begin
        #1;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset div_by_zero", {31'b0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_div(32'h64, 32'h7, 1'b0, 32'd14, 32'd2, 1'b0, 33, -1, -1);
        run_div(32'hFFFFFFF9, 32'h2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33, -1, -1);
        run_div(32'hFFFFFFF9, 32'h2, 1'b0, 32'h7FFFFFFC, 32'h1, 1'b0, 33, -1, -1);
        run_div(32'h7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'h1, 1'b0, 33, -1, -1);
        run_div(32'h1234, 32'h0, 1'b0, 32'hFFFFFFFF, 32'h1234, 1'b1, 1, -1, -1);
        run_div(32'h1234, 32'h0, 1'b1, 32'hFFFFFFFF, 32'h1234, 1'b1, 1, -1, -1);
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0, 1'b0, 33, -1, -1);
        run_div(32'hFFFFFFFF, 32'h1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, 33, -1, -1);
        run_div(32'h64, 32'h7, 1'b0, 32'd14, 32'd2, 1'b0, 33, -1, 20);
        run_div(32'h64, 32'h7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 10, -1);
        run_div(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 33, -1, -1);

        repeat (3) @(posedge clk);
        #1;
        chk("queue drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
